y86_fetch_pipe: RTL and testbench

- Pipelined Y86-64 fetch stage: owns the predicted-PC register, selects the fetch PC from redirect sources, and decodes instruction length and fields.
- Drives the F/D pipeline register consumed by decode, with stall/bubble control from the hazard unit.
- Successor to the single-cycle fetch block: parametrised memory depth, little-endian valC, status codes, branch prediction, redirect, halt latching and a program-load port.

---
 rtl/y86_fetch_pipe_if.sv | 52 +++++
 rtl/y86_fetch_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_y86_fetch_pipe.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/y86_fetch_pipe_if.sv
// Bundles the fetch stage's program-load port, hazard and redirect inputs and the F/D register outputs.
// perf_instr/perf_bubble are present only when FETCH_PERF_CNT_EN is defined.
interface y86_fetch_pipe_if #(
  parameter int AW = 10
);
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [7:0]    imem_wdata;
  logic          F_stall;
  logic          D_stall;
  logic          D_bubble;
  logic [3:0]    M_icode;
  logic          M_cnd;
  logic [63:0]   M_valA;
  logic [3:0]    W_icode;
  logic [63:0]   W_valM;
  logic [63:0]   F_predPC;
  logic [2:0]    D_stat;
  logic [3:0]    D_icode;
  logic [3:0]    D_ifun;
  logic [3:0]    D_rA;
  logic [3:0]    D_rB;
  logic [63:0]   D_valC;
  logic [63:0]   D_valP;
  logic          halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_instr;
  logic [31:0]   perf_bubble;
`endif

  modport master (
    output imem_we, imem_waddr, imem_wdata,
    output F_stall, D_stall, D_bubble,
    output M_icode, M_cnd, M_valA, W_icode, W_valM,
    input  F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    input  halted
`ifdef FETCH_PERF_CNT_EN
    , input perf_instr, perf_bubble
`endif
  );

  modport slave (
    input  imem_we, imem_waddr, imem_wdata,
    input  F_stall, D_stall, D_bubble,
    input  M_icode, M_cnd, M_valA, W_icode, W_valM,
    output F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    output halted
`ifdef FETCH_PERF_CNT_EN
    , output perf_instr, perf_bubble
`endif
  );
endinterface

// File: rtl/y86_fetch_pipe.sv
// Y86-64 pipelined fetch: PC select, length/field decode, branch prediction, F/D register (FETCH_PERF_CNT_EN adds counters).
// Latency: one edge from f_pc selection to D_* outputs; F_predPC updates on the same edge.
// Backpressure: F_stall holds F_predPC, D_stall holds F/D (beats D_bubble); halted freezes fetch until a redirect.
module y86_fetch_pipe #(
  parameter int          IMEM_BYTES = 1024,
  parameter int          AW         = 10,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input logic             clk,
  input logic             rst_n,
  y86_fetch_pipe_if.slave fp
);

  typedef enum logic [2:0] {
    STAT_BUB = 3'd0,
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef struct packed {
    stat_t       stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } fd_t;

  localparam fd_t FD_BUBBLE = '{
    stat:  STAT_BUB,
    icode: 4'h1,
    ifun:  4'h0,
    ra:    4'hF,
    rb:    4'hF,
    valc:  64'h0,
    valp:  64'h0
  };

  localparam logic [63:0] MEM_LIMIT = 64'(IMEM_BYTES);

  logic [7:0]  mem [IMEM_BYTES];

  logic [63:0] pred_pc_q;
  logic        halted_q;
  fd_t         d_q;
  fd_t         d_fetch;

  logic        mispred;
  logic        ret_wb;
  logic        redirect;
  logic [63:0] f_pc;
  logic [7:0]  fb [10];

  logic [3:0]  raw_icode;
  logic [3:0]  raw_ifun;
  logic        need_regids;
  logic        need_valc;
  logic        instr_valid;
  logic [3:0]  ilen;
  logic [63:0] f_valc;
  logic [63:0] f_valp;
  logic        imem_error;
  logic [3:0]  f_icode;
  stat_t       f_stat;
  logic [63:0] f_pred;

  logic        d_load_fetch;
  logic        d_load_bub;

  // Program-load port; memory has no reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (fp.imem_we && (64'(fp.imem_waddr) < MEM_LIMIT)) begin
      mem[fp.imem_waddr] <= fp.imem_wdata;
    end
  end

  assign mispred  = (fp.M_icode == 4'h7) && !fp.M_cnd;
  assign ret_wb   = (fp.W_icode == 4'h9);
  assign redirect = mispred || ret_wb;

  always_comb begin
    f_pc = pred_pc_q;
    if (mispred) begin
      f_pc = fp.M_valA;
    end else if (ret_wb) begin
      f_pc = fp.W_valM;
    end
  end

  // Out-of-range bytes read as zero and never address the array.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      logic [63:0] a;
      a     = f_pc + 64'(k);
      fb[k] = 8'h00;
      if ((f_pc < MEM_LIMIT) && (a < MEM_LIMIT)) begin
        fb[k] = mem[a[AW-1:0]];
      end
    end
  end

  assign raw_icode = fb[0][7:4];
  assign raw_ifun  = fb[0][3:0];

  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    instr_valid = 1'b1;
    case (raw_icode)
      4'h0, 4'h1, 4'h9:       ;
      4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
      4'h7, 4'h8:             need_valc = 1'b1;
      4'h3, 4'h4, 4'h5: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      default:                instr_valid = 1'b0;
    endcase
  end

  assign ilen = 4'd1 + {3'd0, need_regids} + {need_valc, 3'd0};

  always_comb begin
    f_valc = 64'h0;
    if (need_valc) begin
      if (need_regids) begin
        f_valc = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]};
      end else begin
        f_valc = {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
      end
    end
  end

  assign f_valp = f_pc + 64'(ilen);

  // f_pc in range guarantees f_valp - 1 cannot wrap.
  assign imem_error = (f_pc >= MEM_LIMIT) || ((f_valp - 64'd1) >= MEM_LIMIT);

  assign f_icode = imem_error ? 4'h1 : raw_icode;

  always_comb begin
    f_stat = STAT_AOK;
    if (imem_error) begin
      f_stat = STAT_ADR;
    end else if (!instr_valid) begin
      f_stat = STAT_INS;
    end else if (raw_icode == 4'h0) begin
      f_stat = STAT_HLT;
    end
  end

  assign f_pred = ((f_icode == 4'h7) || (f_icode == 4'h8)) ? f_valc : f_valp;

  always_comb begin
    d_fetch       = FD_BUBBLE;
    d_fetch.stat  = f_stat;
    d_fetch.icode = f_icode;
    d_fetch.ifun  = imem_error ? 4'h0 : raw_ifun;
    d_fetch.ra    = need_regids ? fb[1][7:4] : 4'hF;
    d_fetch.rb    = need_regids ? fb[1][3:0] : 4'hF;
    d_fetch.valc  = f_valc;
    d_fetch.valp  = f_valp;
  end

  assign d_load_fetch = !fp.D_stall && !fp.D_bubble && !(halted_q && !redirect);
  assign d_load_bub   = !fp.D_stall && !d_load_fetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc_q <= RESET_PC;
      halted_q  <= 1'b0;
      d_q       <= FD_BUBBLE;
    end else begin
      if (!fp.F_stall && (!halted_q || redirect)) begin
        pred_pc_q <= f_pred;
      end
      if (d_load_fetch) begin
        d_q <= d_fetch;
      end else if (d_load_bub) begin
        d_q <= FD_BUBBLE;
      end
      // A faulting fetch at the redirect target must still freeze fetch.
      if (d_load_fetch && (f_stat != STAT_AOK)) begin
        halted_q <= 1'b1;
      end else if (redirect) begin
        halted_q <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_instr_q;
  logic [31:0] perf_bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_q  <= 32'h0;
      perf_bubble_q <= 32'h0;
    end else begin
      if (d_load_fetch && (perf_instr_q != 32'hFFFF_FFFF)) begin
        perf_instr_q <= perf_instr_q + 32'd1;
      end
      if (d_load_bub && (perf_bubble_q != 32'hFFFF_FFFF)) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end

  assign fp.perf_instr  = perf_instr_q;
  assign fp.perf_bubble = perf_bubble_q;
`endif

  assign fp.F_predPC = pred_pc_q;
  assign fp.D_stat   = d_q.stat;
  assign fp.D_icode  = d_q.icode;
  assign fp.D_ifun   = d_q.ifun;
  assign fp.D_rA     = d_q.ra;
  assign fp.D_rB     = d_q.rb;
  assign fp.D_valC   = d_q.valc;
  assign fp.D_valP   = d_q.valp;
  assign fp.halted   = halted_q;

endmodule

// File: tb/tb_y86_fetch_pipe.sv
// Directed bench for y86_fetch_pipe: program load, decode, prediction, redirect, halt, faults, stall and async reset.
module tb_y86_fetch_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  y86_fetch_pipe_if #(.AW(10)) fp ();

  y86_fetch_pipe #(
    .IMEM_BYTES(1024),
    .AW        (10),
    .RESET_PC  (64'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fp   (fp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [9:0] addr, input logic [7:0] data);
    fp.imem_we    = 1'b1;
    fp.imem_waddr = addr;
    fp.imem_wdata = data;
    step();
    fp.imem_we    = 1'b0;
  endtask

  task automatic ret_to(input logic [63:0] pc);
    fp.W_icode = 4'h9;
    fp.W_valM  = pc;
    step();
    fp.W_icode = 4'h0;
    fp.W_valM  = 64'h0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    fp.imem_we    = 1'b0;
    fp.imem_waddr = '0;
    fp.imem_wdata = 8'h00;
    fp.F_stall    = 1'b0;
    fp.D_stall    = 1'b0;
    fp.D_bubble   = 1'b0;
    fp.M_icode    = 4'h0;
    fp.M_cnd      = 1'b0;
    fp.M_valA     = 64'h0;
    fp.W_icode    = 4'h0;
    fp.W_valM     = 64'h0;

    // Program image loaded while held in reset.
    wb(10'h000, 8'h30); wb(10'h001, 8'hF4); wb(10'h002, 8'h0A);
    for (int i = 3; i < 10; i++) wb(10'(i), 8'h00);
    wb(10'h010, 8'h60); wb(10'h011, 8'h12);
    wb(10'h020, 8'h70); wb(10'h021, 8'h40);
    for (int i = 8'h22; i < 8'h29; i++) wb(10'(i), 8'h00);
    wb(10'h029, 8'h10);
    wb(10'd1020, 8'h30);
    wb(10'd1023, 8'h10);

    chk("rst_predpc", fp.F_predPC, 64'h0);
    chk("rst_stat",   64'(fp.D_stat), 64'd0);
    chk("rst_icode",  64'(fp.D_icode), 64'd1);
    chk("rst_rA",     64'(fp.D_rA), 64'hF);
    chk("rst_rB",     64'(fp.D_rB), 64'hF);
    chk("rst_valC",   fp.D_valC, 64'h0);
    chk("rst_halted", 64'(fp.halted), 64'd0);

    // irmovq $10, %rsp at 0
    rst_n = 1'b1;
    step();
    chk("irm_icode",  64'(fp.D_icode), 64'd3);
    chk("irm_rA",     64'(fp.D_rA), 64'hF);
    chk("irm_rB",     64'(fp.D_rB), 64'h4);
    chk("irm_valC",   fp.D_valC, 64'd10);
    chk("irm_valP",   fp.D_valP, 64'd10);
    chk("irm_stat",   64'(fp.D_stat), 64'd1);
    chk("irm_predpc", fp.F_predPC, 64'd10);

    wb(10'h005, 8'h00);

    // jXX 0x40 at 0x20, predicted taken
    ret_to(64'h20);
    chk("jxx_icode",  64'(fp.D_icode), 64'd7);
    chk("jxx_valC",   fp.D_valC, 64'h40);
    chk("jxx_valP",   fp.D_valP, 64'h29);
    chk("jxx_stat",   64'(fp.D_stat), 64'd1);
    chk("jxx_predpc", fp.F_predPC, 64'h40);

    // Mispredict redirect outranks a simultaneous ret
    fp.M_icode = 4'h7; fp.M_cnd = 1'b0; fp.M_valA = 64'h29;
    fp.W_icode = 4'h9; fp.W_valM = 64'h20;
    step();
    fp.M_icode = 4'h0; fp.M_valA = 64'h0; fp.W_icode = 4'h0; fp.W_valM = 64'h0;
    chk("mis_icode",  64'(fp.D_icode), 64'd1);
    chk("mis_valP",   fp.D_valP, 64'h2A);
    chk("mis_predpc", fp.F_predPC, 64'h2A);

    // halt at 0x05
    ret_to(64'h05);
    chk("hlt_stat",   64'(fp.D_stat), 64'd2);
    chk("hlt_icode",  64'(fp.D_icode), 64'd0);
    chk("hlt_halted", 64'(fp.halted), 64'd1);
    chk("hlt_predpc", fp.F_predPC, 64'h06);
    step();
    chk("hlt_bub_stat",  64'(fp.D_stat), 64'd0);
    chk("hlt_bub_icode", 64'(fp.D_icode), 64'd1);
    step();
    chk("hlt_hold_predpc", fp.F_predPC, 64'h06);
    chk("hlt_hold_halted", 64'(fp.halted), 64'd1);

    // ret to 0x10 (OPq rA=1 rB=2) resumes fetch
    ret_to(64'h10);
    chk("res_halted", 64'(fp.halted), 64'd0);
    chk("res_icode",  64'(fp.D_icode), 64'd6);
    chk("res_rA",     64'(fp.D_rA), 64'h1);
    chk("res_rB",     64'(fp.D_rB), 64'h2);
    chk("res_valC",   fp.D_valC, 64'h0);
    chk("res_valP",   fp.D_valP, 64'h12);
    chk("res_predpc", fp.F_predPC, 64'h12);

    // irmovq straddling the end of memory
    ret_to(64'd1020);
    chk("adr_stat",   64'(fp.D_stat), 64'd3);
    chk("adr_icode",  64'(fp.D_icode), 64'd1);
    chk("adr_ifun",   64'(fp.D_ifun), 64'd0);
    chk("adr_halted", 64'(fp.halted), 64'd1);

    // nop in the last byte is still legal
    ret_to(64'd1023);
    chk("edge_stat", 64'(fp.D_stat), 64'd1);
    chk("edge_valP", fp.D_valP, 64'd1024);

    wb(10'h000, 8'hE0);
    ret_to(64'h0);
    chk("ins_stat",  64'(fp.D_stat), 64'd4);
    chk("ins_icode", 64'(fp.D_icode), 64'hE);

    // Stall beats bubble; F_stall holds the PC
    ret_to(64'h10);
    fp.D_stall = 1'b1; fp.D_bubble = 1'b1; fp.F_stall = 1'b1;
    step();
    chk("stall_icode",  64'(fp.D_icode), 64'd6);
    chk("stall_stat",   64'(fp.D_stat), 64'd1);
    chk("stall_valP",   fp.D_valP, 64'h12);
    chk("stall_predpc", fp.F_predPC, 64'h12);
    fp.D_stall = 1'b0; fp.D_bubble = 1'b0; fp.F_stall = 1'b0;

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_predpc", fp.F_predPC, 64'h0);
    chk("arst_stat",   64'(fp.D_stat), 64'd0);
    chk("arst_icode",  64'(fp.D_icode), 64'd1);
    chk("arst_rB",     64'(fp.D_rB), 64'hF);
    chk("arst_valP",   fp.D_valP, 64'h0);
    chk("arst_halted", 64'(fp.halted), 64'd0);
    rst_n = 1'b1;
    step();
    chk("keep_mem_stat",  64'(fp.D_stat), 64'd4);
    chk("keep_mem_icode", 64'(fp.D_icode), 64'hE);

`ifdef FETCH_PERF_CNT_EN
    rst_n = 1'b0;
    wb(10'h000, 8'h10); wb(10'h001, 8'h10); wb(10'h002, 8'h10);
    chk("perf_rst_instr",  64'(fp.perf_instr), 64'd0);
    chk("perf_rst_bubble", 64'(fp.perf_bubble), 64'd0);
    rst_n = 1'b1;
    step(); step(); step();
    fp.D_bubble = 1'b1;
    step(); step();
    fp.D_bubble = 1'b0;
    fp.D_stall  = 1'b1;
    step();
    chk("perf_instr",  64'(fp.perf_instr), 64'd3);
    chk("perf_bubble", 64'(fp.perf_bubble), 64'd2);
    fp.D_stall = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
